// File: rtl/pipe_stream_generator.sv
// Serial pipe-column bit stream for the scrolling playfield shift register.
// PIPE_GEN_FIXED_PATTERN_EN: drop the LFSR for a deterministic bring-up pattern.
module pipe_stream_generator #(
  parameter int          PIPE_WIDTH     = 4,
  parameter int          MIN_GAP        = 6,
  parameter int          GAP_RANGE_BITS = 3,
  parameter int          GAP_Y_MIN      = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       advance,
  output logic       bit_out,
  output logic       bit_strobe,
  output logic       pipe_start,
  output logic [6:0] gap_y,
  output logic [7:0] pipe_count
);

  typedef enum logic [1:0] {
    IDLE,
    SPACE,
    PIPE
  } state_t;

  localparam int LEN_MAX = MIN_GAP + (1 << GAP_RANGE_BITS) - 1;
  localparam int CNT_MAX = (LEN_MAX > PIPE_WIDTH) ? LEN_MAX : PIPE_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] len;
  logic [6:0]    gap_new;
  logic          bit_n, strobe_n, start_n;
  logic [6:0]    gap_n;
  logic [7:0]    count_n;
  logic          acc;

  assign acc = enable & advance;

`ifdef PIPE_GEN_FIXED_PATTERN_EN
  assign len     = CW'(MIN_GAP);
  assign gap_new = 7'(GAP_Y_MIN + 32);
`else
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr;
  logic        fb;

  // taps 16,14,13,11 of x^16+x^14+x^13+x^11+1
  assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign len     = CW'(MIN_GAP) + CW'(lfsr[GAP_RANGE_BITS-1:0]);
  assign gap_new = 7'(GAP_Y_MIN) + {1'b0, lfsr[15:12], 2'b00};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= SEED;
    end else if (acc) begin
      lfsr <= {lfsr[14:0], fb};
    end
  end
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_out;
    strobe_n = 1'b0;
    start_n  = 1'b0;
    gap_n    = gap_y;
    count_n  = pipe_count;
    if (acc) begin
      strobe_n = 1'b1;
      unique case (state)
        IDLE: begin
          bit_n   = 1'b0;
          state_n = SPACE;
          cnt_n   = len - CW'(1);
        end
        SPACE: begin
          bit_n = 1'b0;
          if (cnt == CW'(1)) begin
            state_n = PIPE;
            cnt_n   = CW'(PIPE_WIDTH);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        PIPE: begin
          bit_n = 1'b1;
          if (cnt == CW'(PIPE_WIDTH)) begin
            start_n = 1'b1;
            gap_n   = gap_new;
            if (pipe_count != 8'hFF) begin
              count_n = pipe_count + 8'd1;
            end
          end
          if (cnt == CW'(1)) begin
            state_n = SPACE;
            cnt_n   = len;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_out    <= 1'b0;
      bit_strobe <= 1'b0;
      pipe_start <= 1'b0;
      gap_y      <= 7'(GAP_Y_MIN);
      pipe_count <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_out    <= bit_n;
      bit_strobe <= strobe_n;
      pipe_start <= start_n;
      gap_y      <= gap_n;
      pipe_count <= count_n;
    end
  end

endmodule

// File: tb/tb_pipe_stream_generator.sv
// Bench for pipe_stream_generator: vector table, held advance, async reset,
// and a long randomized run against a precomputed stream model.
module tb_pipe_stream_generator;

  localparam int PW    = 4;
  localparam int MG    = 6;
  localparam int GYMIN = 16;
  localparam int NMAX  = 6000;
`ifdef PIPE_GEN_FIXED_PATTERN_EN
  localparam int FZ = 6;
`else
  localparam int FZ = 7;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       advance = 1'b0;
  logic       bit_out, bit_strobe, pipe_start;
  logic [6:0] gap_y;
  logic [7:0] pipe_count;

  pipe_stream_generator dut (
    .clk(clk), .resetn(resetn), .enable(enable), .advance(advance),
    .bit_out(bit_out), .bit_strobe(bit_strobe), .pipe_start(pipe_start),
    .gap_y(gap_y), .pipe_count(pipe_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit adv;
    bit e_strobe;
    bit e_bit;
    bit e_start;
  } vec_t;

  vec_t tbl[32];
  int   ntbl;

  logic [15:0] lf [NMAX+1];
  bit          eb [NMAX];
  bit          es [NMAX];
  int          eg [NMAX];
  int          ec [NMAX];
  int          start300;

  int   checks = 0;
  int   errors = 0;
  int   acc;
  bit   last_bit;

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int len_of(logic [15:0] l);
`ifdef PIPE_GEN_FIXED_PATTERN_EN
    return MG;
`else
    return MG + int'(l[2:0]);
`endif
  endfunction

  function automatic int gap_of(logic [15:0] l);
`ifdef PIPE_GEN_FIXED_PATTERN_EN
    return GYMIN + 32;
`else
    return GYMIN + 4 * int'(l[15:12]);
`endif
  endfunction

  // Expected stream per accepted advance: zeros, then PW ones, repeated.
  task automatic build_model();
    int pos, samp, starts, g, z;
    lf[0] = 16'hACE1;
    for (int i = 0; i < NMAX; i++) lf[i+1] = lfsr_next(lf[i]);
    pos = 0; samp = 0; starts = 0; g = GYMIN; start300 = -1;
    while (pos < NMAX) begin
      z = len_of(lf[samp]);
      for (int k = 0; k < z && pos < NMAX; k++) begin
        eb[pos] = 0; es[pos] = 0; eg[pos] = g;
        ec[pos] = (starts > 255) ? 255 : starts;
        pos++;
      end
      for (int k = 0; k < PW && pos < NMAX; k++) begin
        if (k == 0) begin
          g = gap_of(lf[pos]);
          starts++;
          if (starts == 300) start300 = pos;
        end
        eb[pos] = 1; es[pos] = (k == 0); eg[pos] = g;
        ec[pos] = (starts > 255) ? 255 : starts;
        pos++;
      end
      samp = pos - 1;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(bit en, bit adv);
    enable = en;
    advance = adv;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(bit en, bit adv);
    step(en, adv);
    if (en && adv) begin
      chk("strobe", 32'(bit_strobe), 1);
      chk("bit", 32'(bit_out), 32'(eb[acc]));
      chk("start", 32'(pipe_start), 32'(es[acc]));
      chk("gap_y", 32'(gap_y), 32'(eg[acc]));
      chk("count", 32'(pipe_count), 32'(ec[acc]));
      if (pipe_start) begin
        chk("gap_range", 32'((gap_y >= GYMIN) && (gap_y <= GYMIN + 60)), 1);
        chk("gap_mod4", 32'(gap_y[1:0]), 0);
      end
      last_bit = eb[acc];
      acc++;
    end else begin
      chk("idle_strobe", 32'(bit_strobe), 0);
      chk("idle_start", 32'(pipe_start), 0);
      chk("hold_bit", 32'(bit_out), 32'(last_bit));
      chk("hold_gap", 32'(gap_y), (acc == 0) ? GYMIN : eg[acc-1]);
      chk("hold_count", 32'(pipe_count), (acc == 0) ? 0 : ec[acc-1]);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_bit"}, 32'(bit_out), 0);
    chk({tag, "_strobe"}, 32'(bit_strobe), 0);
    chk({tag, "_start"}, 32'(pipe_start), 0);
    chk({tag, "_gap"}, 32'(gap_y), GYMIN);
    chk({tag, "_count"}, 32'(pipe_count), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    enable = 1'b0;
    advance = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    acc = 0;
    last_bit = 0;
  endtask

  initial begin
    int cyc;
    // idle, leading zeros, paused advances, pipe, idle
    ntbl = 0;
    tbl[ntbl++] = '{1, 0, 0, 0, 0};
    for (int i = 0; i < FZ; i++) tbl[ntbl++] = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 3; i++) tbl[ntbl++] = '{0, 1, 0, 0, 0};
    tbl[ntbl++] = '{1, 1, 1, 1, 1};
    for (int i = 0; i < 3; i++) tbl[ntbl++] = '{1, 1, 1, 1, 0};
    tbl[ntbl++] = '{1, 0, 0, 1, 0};

    build_model();
    do_reset();
    #1;
    chk_reset_vals("rst");

    for (int i = 0; i < ntbl; i++) begin
      step(tbl[i].en, tbl[i].adv);
      chk($sformatf("tbl%0d_strobe", i), 32'(bit_strobe), 32'(tbl[i].e_strobe));
      chk($sformatf("tbl%0d_bit", i), 32'(bit_out), 32'(tbl[i].e_bit));
      chk($sformatf("tbl%0d_start", i), 32'(pipe_start), 32'(tbl[i].e_start));
    end
    chk("tbl_count", 32'(pipe_count), 1);

    // advance held high: one bit per cycle, then strobe drops
    do_reset();
    for (int i = 0; i < 40; i++) step_chk(1, 1);
    step_chk(1, 0);
    step_chk(0, 1);

    // async reset asserted between edges during bit 9
    do_reset();
    for (int i = 0; i < 9; i++) step_chk(1, 1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_reset_vals("async");
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    acc = 0;
    last_bit = 0;
    for (int i = 0; i < FZ + PW + 2; i++) step_chk(1, 1);

    // long random run past 300 pipes
    do_reset();
    cyc = 0;
    while (acc <= start300 + PW && acc < NMAX - 1 && cyc < 30000) begin
      step_chk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("run_done", 32'(acc > start300 + PW), 1);
    chk("sat_count", 32'(pipe_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
